// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one registered ALU.
// Round-robin grant, one transaction in flight, response held until taken.
// Optional build macro ALU_ARB_OPCHECK_EN: opcodes above SUB bypass the ALU
// and return an error response one cycle after accept.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic [3:0]       alu_op_q;
    logic [WIDTH-1:0] alu_in1_q;
    logic [WIDTH-1:0] alu_in2_q;

    logic             grant;
    logic             any_valid;
    logic             accept;
    logic             op_illegal;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin grant and selection of the granted requester's operands
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        any_valid = req0_valid | req1_valid;
        accept    = (state_q == ST_IDLE) && any_valid;
        sel_op    = grant ? req1_op : req0_op;
        sel_a     = grant ? req1_a  : req0_a;
        sel_b     = grant ? req1_b  : req0_b;
`ifdef ALU_ARB_OPCHECK_EN
        op_illegal = (sel_op > 4'd3);
`else
        op_illegal = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, handshake outputs
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_d    = op_illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch and response capture. The latched operands are the ALU
    // drive registers themselves, so the ALU sees them during EXEC and its
    // registered result is ready to capture in WAIT. They only change on a
    // legal accept, so they hold steady through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            alu_op_q     <= 4'd0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= grant;
                rsp_id_q     <= grant;
                if (op_illegal) begin
                    rsp_result_q <= '0;
                    rsp_zero_q   <= 1'b0;
                end else begin
                    alu_op_q  <= sel_op;
                    alu_in1_q <= sel_a;
                    alu_in2_q <= sel_b;
                end
            end
            if (state_q == ST_WAIT) begin
                rsp_result_q <= alu_out;
                rsp_zero_q   <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic rsp_err_q;

    // Error flag: set on an illegal-opcode accept, cleared on a legal one
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= op_illegal;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign alu_op     = alu_op_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a registered ALU attached.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [3:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_in1, alu_in2;
    logic [WIDTH-1:0] alu_out = '0;
    logic             alu_zero = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Shared ALU: result registered one cycle after its inputs
    always @(posedge clk) begin
        logic [WIDTH-1:0] r;
        case (alu_op)
            4'd0:    r = alu_in1 & alu_in2;
            4'd1:    r = alu_in1 | alu_in2;
            4'd2:    r = alu_in1 + alu_in2;
            4'd3:    r = alu_in1 - alu_in2;
            default: r = '0;
        endcase
        alu_out  <= r;
        alu_zero <= (r == '0);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one request from IDLE (called at posedge+1) and follow it to
    // consumption; rsp_ready is expected high.
    task automatic run_op(input bit id, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int exp_lat,
                          input logic [WIDTH-1:0] exp_res, input bit exp_zero, input bit exp_err);
        int lat;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        check_val("accept_ready", id ? req1_ready : req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", 64'(lat), 64'(exp_lat));
        check_val("rsp_result", rsp_result, exp_res);
        check_val("rsp_zero", rsp_zero, exp_zero);
        check_val("rsp_id", rsp_id, id);
        check_val("rsp_err", rsp_err, exp_err);
        @(posedge clk); #1;
        check_val("rsp_consumed", rsp_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int bad;
        int grants[$];
        logic [WIDTH-1:0] results[$];

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'd0; req1_op = 4'd0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_rsp_id", rsp_id, 1'b0);
        check_val("rst_rsp_result", rsp_result, 32'd0);
        check_val("rst_rsp_zero", rsp_zero, 1'b0);
        check_val("rst_rsp_err", rsp_err, 1'b0);
        check_val("rst_alu_op", alu_op, 4'd0);
        check_val("rst_alu_in1", alu_in1, 32'd0);
        check_val("rst_alu_in2", alu_in2, 32'd0);
        check_val("rst_readies", {req0_ready, req1_ready}, 2'b00);

        // req0 ADD 5+7
        run_op(1'b0, 4'd2, 32'd5, 32'd7, 3, 32'd12, 1'b0, 1'b0);
        // ALU drive holds in IDLE
        check_val("hold_alu_op", alu_op, 4'd2);
        check_val("hold_alu_in1", alu_in1, 32'd5);
        check_val("hold_alu_in2", alu_in2, 32'd7);

        // req1 SUB 9-9
        run_op(1'b1, 4'd3, 32'd9, 32'd9, 3, 32'd0, 1'b1, 1'b0);

        // Illegal opcode 0111
`ifdef ALU_ARB_OPCHECK_EN
        run_op(1'b0, 4'd7, 32'd5, 32'd3, 1, 32'd0, 1'b0, 1'b1);
        check_val("opchk_alu_op", alu_op, 4'd3);
        check_val("opchk_alu_in1", alu_in1, 32'd9);
`else
        run_op(1'b0, 4'd7, 32'd5, 32'd3, 3, 32'd0, 1'b1, 1'b0);
        check_val("noopchk_alu_op", alu_op, 4'd7);
`endif

        // Back-pressure: response held 5 cycles, no readies meanwhile
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd3; req1_b = 32'd4;
        #1;
        check_val("stall_accept", req1_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("stall_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check_val("stall_valid", rsp_valid, 1'b1);
            check_val("stall_result", rsp_result, 32'd7);
            check_val("stall_id", rsp_id, 1'b1);
            check_val("stall_readies", {req0_ready, req1_ready}, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check_val("consume_valid", rsp_valid, 1'b1);
        check_val("consume_readies", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        check_val("stall_consumed", rsp_valid, 1'b0);

        // Reset pulsed while in WAIT drops the transaction
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        check_val("rstw_accept", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rstw_rsp_valid", rsp_valid, 1'b0);
        check_val("rstw_rsp_result", rsp_result, 32'd0);
        check_val("rstw_rsp_id", rsp_id, 1'b0);
        check_val("rstw_alu_op", alu_op, 4'd0);
        check_val("rstw_alu_in1", alu_in1, 32'd0);
        check_val("rstw_alu_in2", alu_in2, 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) bad++;
            @(posedge clk); #1;
        end
        check_val("rstw_no_rsp", 64'(bad), 64'd0);
        req0_valid = 1'b1;
        #1;
        check_val("rstw_idle", req0_ready, 1'b1);
        req0_valid = 1'b0;
        #1;

        // Round-robin from reset with both requesters always valid
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'hF0; req0_b = 32'h3C;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'hF0; req1_b = 32'h0F;
        #1;
        for (int i = 0; i < 40 && results.size() < 4; i++) begin
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid)  results.push_back(rsp_result);
            @(posedge clk); #2;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_val("rr_count", 64'(results.size()), 64'd4);
        while (grants.size() < 4) grants.push_back(-1);
        while (results.size() < 4) results.push_back('x);
        check_val("rr_grant0", 64'(grants[0]), 64'd0);
        check_val("rr_grant1", 64'(grants[1]), 64'd1);
        check_val("rr_grant2", 64'(grants[2]), 64'd0);
        check_val("rr_grant3", 64'(grants[3]), 64'd1);
        check_val("rr_result0", results[0], 32'h30);
        check_val("rr_result1", results[1], 32'hFF);
        check_val("rr_result2", results[2], 32'h30);
        check_val("rr_result3", results[3], 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
- REQ-001: Parameter WIDTH, default 32, datapath width of operands and result.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  synchronous active-high reset.
- REQ-004: req0_valid / req1_valid  input  1  requester N has an operation pending.
- REQ-005: req0_op / req1_op  input  4  ALU opcode (0000 AND, 0001 OR, 0010 ADD, 0011 SUB).
- REQ-006: req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
- REQ-007: req0_ready / req1_ready  output  1  request accepted this cycle.
- REQ-008: rsp_valid  output  1  response held valid.
- REQ-009: rsp_ready  input  1  consumer takes response.
- REQ-010: rsp_id  output  1  requester that owns the response.
- REQ-011: rsp_result  output  WIDTH  captured ALU result; rsp_zero  output  1  captured zero flag; rsp_err  output  1  illegal opcode flag.
- REQ-012: alu_op  output  4, alu_in1 / alu_in2  output  WIDTH  drive shared ALU.
- REQ-013: alu_out  input  WIDTH, alu_zero  input  1  from shared ALU, registered (valid one cycle after inputs are applied).

Function
- REQ-014: FSM states IDLE, EXEC, WAIT, RESP; one transaction in flight at a time.
- REQ-015: IDLE: reqN_ready = 1 combinationally for exactly the granted requester; both readies 0 in all other states.
- REQ-016: Grant: only one valid -> grant it; both valid -> grant requester not equal to last_grant (round-robin).
- REQ-017: On accept (valid && ready), latch op, a, b, id into internal registers, update last_grant, go to EXEC.
- REQ-018: EXEC: drive alu_op/alu_in1/alu_in2 from latched registers; go to WAIT.
- REQ-019: WAIT: keep ALU inputs stable; capture alu_out into rsp_result and alu_zero into rsp_zero; go to RESP.
- REQ-020: RESP: rsp_valid = 1, rsp_result/rsp_zero/rsp_id/rsp_err stable until rsp_valid && rsp_ready; then IDLE.
- REQ-021: Latency: accept in cycle N -> rsp_valid first high in cycle N+3; throughput max one op per 4 cycles with rsp_ready held high.
- REQ-022: No new accept in the cycle a response is consumed; next accept earliest in following IDLE cycle.
- REQ-023: In IDLE, alu_op/alu_in1/alu_in2 hold the last driven values (no toggling).
- REQ-024: Requester deasserting valid without ready is permitted; no side effect.

Reset
- REQ-025: rst high at any state, including mid-transaction, returns FSM to IDLE next edge; in-flight transaction dropped, no response issued.
- REQ-026: Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0, alu_op 0000, alu_in1 0, alu_in2 0, last_grant 1 (requester 0 wins first contention).

Configuration
- REQ-027: Macro ALU_ARB_OPCHECK_EN defined: opcode > 0011 is accepted, skips EXEC/WAIT, goes IDLE -> RESP with rsp_err 1, rsp_result 0, rsp_zero 0, ALU inputs untouched.
- REQ-028: Macro ALU_ARB_OPCHECK_EN undefined: all opcodes go through the ALU; rsp_err tied 0.

Verification
- REQ-029: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready cycle N, rsp_valid cycle N+3, rsp_result 12, rsp_zero 0, rsp_id 0.
- REQ-030: req1 SUB a=9 b=9 -> rsp_result 0, rsp_zero 1, rsp_id 1.
- REQ-031: Both valid continuously from reset (req0 AND 0xF0/0x3C, req1 OR 0xF0/0x0F) -> grant order 0,1,0,1; results 0x30, 0xFF alternating.
- REQ-032: rsp_ready low 5 cycles during RESP -> rsp_valid and fields stable, no readies asserted; consumed on first rsp_ready high.
- REQ-033: rst pulsed in WAIT -> next cycle IDLE, rsp_valid never asserted, all outputs at reset values.
- REQ-034: With ALU_ARB_OPCHECK_EN, req0 op 0111 -> rsp_valid cycle N+1, rsp_err 1, rsp_result 0; without macro -> rsp_err 0, rsp_valid cycle N+3.
